// File: rtl/sclkfifolut_pkg.sv
// Shared constants and pointer helper for the sclkfifolut read-stream adapter.
package sclkfifolut_pkg;

    localparam int unsigned RDSTREAM_BUF_DEPTH = 3;
    localparam int unsigned RDSTREAM_PTR_W     = 2;
    localparam int unsigned RDSTREAM_OCC_W     = 2;

    typedef logic [RDSTREAM_PTR_W-1:0] rdbuf_ptr_t;
    typedef logic [RDSTREAM_OCC_W-1:0] rdbuf_occ_t;

    // Circular increment over a buffer that is not a power of two deep
    function automatic rdbuf_ptr_t rdbuf_ptr_inc(input rdbuf_ptr_t p);
        return (p == rdbuf_ptr_t'(RDSTREAM_BUF_DEPTH - 1)) ? '0 : p + rdbuf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/sclkfifolut.sv
// Single-clock FIFO with registered read data (one-cycle read latency).
module sclkfifolut #(
    parameter int unsigned FIFO_WIDTH      = 32,
    parameter int unsigned LOG2_FIFO_DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       wen,
    input  logic [FIFO_WIDTH-1:0]      wdata,
    output logic                       wfull,
    input  logic                       ren,
    output logic [FIFO_WIDTH-1:0]      rdata,
    output logic                       rempty,
    output logic [LOG2_FIFO_DEPTH:0]   level
);

    localparam int unsigned DEPTH = 1 << LOG2_FIFO_DEPTH;
    localparam int unsigned LVL_W = LOG2_FIFO_DEPTH + 1;

    logic [FIFO_WIDTH-1:0] mem [DEPTH];
    logic [LVL_W-1:0]      wptr;
    logic [LVL_W-1:0]      rptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign level  = wptr - rptr;
    assign rempty = (level == '0);
    assign wfull  = (level == LVL_W'(DEPTH));
    assign wr_ok  = wen && !wfull;
    assign rd_ok  = ren && !rempty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[LOG2_FIFO_DEPTH-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + LVL_W'(1);
            end
            if (rd_ok) begin
                rdata <= mem[rptr[LOG2_FIFO_DEPTH-1:0]];
                rptr  <= rptr + LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/sclkfifolut_rdbuf.sv
// Three-entry circular register buffer with head/tail pointers and occupancy.
module sclkfifolut_rdbuf
    import sclkfifolut_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output rdbuf_occ_t       occ
);

    logic [WIDTH-1:0] mem [RDSTREAM_BUF_DEPTH];
    rdbuf_ptr_t       head;
    rdbuf_ptr_t       tail;

    assign head_data = mem[head];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < int'(RDSTREAM_BUF_DEPTH); i++) begin
                mem[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= rdbuf_ptr_inc(tail);
            end
            if (pop) begin
                head <= rdbuf_ptr_inc(head);
            end
            // Simultaneous push and pop leaves occupancy unchanged
            case ({push, pop})
                2'b10:   occ <= occ + rdbuf_occ_t'(1);
                2'b01:   occ <= occ - rdbuf_occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/sclkfifolut_rdstream.sv
// Read-side adapter: drives FIFO ren, absorbs its read latency, presents valid/ready.
module sclkfifolut_rdstream
    import sclkfifolut_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    output logic                  fifo_ren,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            buf_level
);

    logic       inflight;
    logic       pop;
    rdbuf_occ_t occ;
    logic [2:0] demand;

    // Reserve a buffer slot for every word already in flight; no path from m_ready
    assign demand   = {1'b0, occ} + {2'b00, inflight};
    assign fifo_ren = !arst && !fifo_rempty && (demand <= 3'd2);

    assign m_valid   = (occ != '0);
    assign pop       = m_valid && m_ready;
    assign buf_level = occ;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_ren;
        end
    end

    sclkfifolut_rdbuf #(
        .WIDTH (FIFO_WIDTH)
    ) u_rdbuf (
        .clk       (clk),
        .arst      (arst),
        .push      (inflight),
        .push_data (fifo_rdata),
        .pop       (pop),
        .head_data (m_data),
        .occ       (occ)
    );

endmodule
